// File: rtl/lsf_sched_pkg.sv
// Shared types and helpers for the LSF event scheduler.
package lsf_sched_pkg;

  // Word widths of the hit-extraction -> segment-finder stream.
  localparam int HEG2SFSLC_LEN   = 32;
  localparam int HEG2SFHIT_LEN   = 40;

  // Upper bound on the number of engines the helpers support.
  localparam int MAX_LSF         = 8;

  // Default event lifetime before a forced end-of-frame.
  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROUTE   = 2'd1,
    ST_DISCARD = 2'd2
  } sched_state_t;

  // Engine index -> one-hot strobe vector (MAX_LSF wide, caller slices).
  function automatic logic [MAX_LSF-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [MAX_LSF-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // One-hot strobe vector -> engine index (lowest set bit wins).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_LSF-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_LSF - 1; i >= 0; i--) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lsf_rr_arbiter.sv
// Combinational round-robin search: first eligible engine after ptr.
module lsf_rr_arbiter #(
  parameter int NUM_LSF = 2,
  parameter int IW      = (NUM_LSF > 1) ? $clog2(NUM_LSF) : 1
) (
  input  logic [NUM_LSF-1:0] eligible,
  input  logic [IW-1:0]      ptr,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_idx
);

  int cand;

  // Walk ptr+1, ptr+2, ... wrapping; the first eligible engine is granted.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_LSF; k++) begin
      cand = (int'(ptr) + k) % NUM_LSF;
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/lsf_event_scheduler.sv
// Routes ROI/hit/eof events from one stream to NUM_LSF engines.
//
// Handshake: every *_we input is a single-cycle valid with no back-pressure;
// the scheduler never stalls the stream. Engine-side lsf_af is advisory and
// only affects allocation of new events; once an event is routed all its hits
// follow. Output strobes appear one cycle after the input that caused them.
module lsf_event_scheduler
  import lsf_sched_pkg::*;
#(
  parameter int NUM_LSF        = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [HEG2SFSLC_LEN-1:0] roi,
  input  logic                     roi_we,
  input  logic [HEG2SFHIT_LEN-1:0] mdt_hit,
  input  logic                     mdt_hit_we,
  input  logic                     i_eof,
  input  logic [NUM_LSF-1:0]       lsf_done,
  input  logic [NUM_LSF-1:0]       lsf_af,
  output logic [HEG2SFSLC_LEN-1:0] lsf_roi,
  output logic [NUM_LSF-1:0]       lsf_roi_we,
  output logic [HEG2SFHIT_LEN-1:0] lsf_mdt_hit,
  output logic [NUM_LSF-1:0]       lsf_mdt_hit_we,
  output logic [NUM_LSF-1:0]       lsf_eof,
  output logic [NUM_LSF-1:0]       lsf_busy,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [CNT_WIDTH-1:0]     timeout_count,
  output logic                     sched_error,
  output logic [1:0]               state_dbg
);

  localparam int IW = (NUM_LSF > 1) ? $clog2(NUM_LSF) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t       state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      cur_idx;
  logic [TW-1:0]      timer;

  logic [NUM_LSF-1:0] busy_eff;
  logic [NUM_LSF-1:0] eligible;
  logic               done_err;
  logic               timeout_hit;
  logic               grant_valid;
  logic [IW-1:0]      grant_idx;
  logic [MAX_LSF-1:0] grant_oh_full;
  logic [MAX_LSF-1:0] cur_oh_full;
  logic [NUM_LSF-1:0] grant_oh;
  logic [NUM_LSF-1:0] cur_oh;

  // Completions free engines this cycle so they can be re-granted at once;
  // a completion on an idle engine is a protocol error.
  always_comb begin
    busy_eff      = lsf_busy & ~lsf_done;
    done_err      = |(lsf_done & ~lsf_busy);
    eligible      = ~busy_eff & ~lsf_af;
    timeout_hit   = (state == ST_ROUTE) && (timer == TW'(TIMEOUT_CYCLES - 1));
    grant_oh_full = idx_to_onehot(3'(grant_idx));
    cur_oh_full   = idx_to_onehot(3'(cur_idx));
    grant_oh      = grant_oh_full[NUM_LSF-1:0];
    cur_oh        = cur_oh_full[NUM_LSF-1:0];
  end

  lsf_rr_arbiter #(
    .NUM_LSF (NUM_LSF),
    .IW      (IW)
  ) u_arb (
    .eligible    (eligible),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign state_dbg = state;

  // Scheduler FSM: closes the open event first, then processes a new ROI,
  // so a late assignment of the ROI path overrides the state chosen above.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      rr_ptr         <= IW'(NUM_LSF - 1);
      cur_idx        <= '0;
      timer          <= '0;
      lsf_roi        <= '0;
      lsf_roi_we     <= '0;
      lsf_mdt_hit    <= '0;
      lsf_mdt_hit_we <= '0;
      lsf_eof        <= '0;
      lsf_busy       <= '0;
      drop_count     <= '0;
      timeout_count  <= '0;
      sched_error    <= 1'b0;
    end else begin
      lsf_roi        <= roi;
      lsf_mdt_hit    <= mdt_hit;
      lsf_roi_we     <= '0;
      lsf_mdt_hit_we <= '0;
      lsf_eof        <= '0;
      lsf_busy       <= busy_eff;
      if (done_err) sched_error <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (mdt_hit_we || i_eof) sched_error <= 1'b1;
        end
        ST_ROUTE: begin
          timer <= timer + TW'(1);
          if (mdt_hit_we) lsf_mdt_hit_we <= cur_oh;
          if (roi_we) begin
            lsf_eof <= cur_oh;
          end else if (i_eof) begin
            lsf_eof <= cur_oh;
            state   <= ST_IDLE;
          end else if (timeout_hit) begin
            lsf_eof <= cur_oh;
            state   <= ST_DISCARD;
            if (timeout_count != '1) timeout_count <= timeout_count + CNT_WIDTH'(1);
          end
        end
        ST_DISCARD: begin
          if (i_eof && !roi_we) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (roi_we) begin
        if (grant_valid) begin
          lsf_busy   <= busy_eff | grant_oh;
          lsf_roi_we <= grant_oh;
          rr_ptr     <= grant_idx;
          cur_idx    <= grant_idx;
          timer      <= '0;
          state      <= ST_ROUTE;
        end else begin
          state <= ST_DISCARD;
          if (drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
